// File: rtl/rr_arb_2_1.sv
// rr_arb_2_1: two-source round-robin arbiter feeding one output register.
// A single output stage holds at most one word; it reloads in the same
// cycle the consumer drains it, giving one word per cycle. Each source
// has a free-running acceptance counter.
//
// Handshake: a word moves across an interface on a rising edge where
// valid and ready are both high. A source may drop valid without having
// been accepted. Ready never depends on data. out_data and out_valid are
// held stable while out_valid is high and out_ready is low.
module rr_arb_2_1 #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_valid,
  input  logic [WIDTH-1:0] a_data,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [WIDTH-1:0] b_data,
  output logic             b_ready,
  output logic             sel,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [CNT_W-1:0] cnt_a,
  output logic [CNT_W-1:0] cnt_b
);

  // Output register occupancy. The state variable is the debug hook
  // for checkers: EMPTY means out_valid low, FULL means out_valid high.
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t state;
  logic   last_grant;  // 0 = A was granted last, 1 = B was granted last
  logic   any_valid;
  logic   slot_free;
  logic   load;

  // Grant selection and load decision; depends only on control inputs.
  always_comb begin
    any_valid = a_valid | b_valid;
    slot_free = (state == EMPTY) | out_ready;
    if (a_valid && b_valid) begin
      // Tie: hand the grant to whichever source did not win last time.
      sel = ~last_grant;
    end else if (b_valid) begin
      sel = 1'b1;
    end else begin
      sel = 1'b0;
    end
    // Nothing is accepted while reset is held, so no word slips in.
    load    = slot_free & any_valid & ~rst;
    a_ready = load & ~sel;
    b_ready = load & sel;
  end

  // Output register FSM: load on grant, drain to EMPTY when consumed
  // with nothing to replace it, otherwise hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= EMPTY;
      out_valid  <= 1'b0;
      out_data   <= '0;
      last_grant <= 1'b1;  // so A wins the first tie after reset
    end else begin
      case (state)
        EMPTY: begin
          if (load) begin
            state      <= FULL;
            out_valid  <= 1'b1;
            out_data   <= sel ? b_data : a_data;
            last_grant <= sel;
          end
        end
        FULL: begin
          if (load) begin
            // Old word leaves and new word enters on the same edge.
            state      <= FULL;
            out_valid  <= 1'b1;
            out_data   <= sel ? b_data : a_data;
            last_grant <= sel;
          end else if (out_ready) begin
            // Drained with no replacement; out_data keeps its last value.
            state     <= EMPTY;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= EMPTY;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  // Per-source acceptance counters; they wrap from all-ones to zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_a <= '0;
      cnt_b <= '0;
    end else begin
      if (a_ready) cnt_a <= cnt_a + CNT_ONE;
      if (b_ready) cnt_b <= cnt_b + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_rr_arb_2_1.sv
// tb_rr_arb_2_1: directed scenarios plus randomized traffic for the
// round-robin arbiter, checked against a behavioural model.
module tb_rr_arb_2_1;

  localparam int WIDTH = 8;
  localparam int CNT_W = 16;

  logic             clk;
  logic             rst;
  logic             a_valid;
  logic [WIDTH-1:0] a_data;
  logic             a_ready;
  logic             b_valid;
  logic [WIDTH-1:0] b_data;
  logic             b_ready;
  logic             sel;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;
  logic [CNT_W-1:0] cnt_a;
  logic [CNT_W-1:0] cnt_b;

  int total;
  int bad;

  // Model state: what the output register and counters should hold.
  bit              m_valid;
  logic [WIDTH-1:0] m_data;
  int              m_last;   // source that won the previous grant: 0=A, 1=B
  int              m_cnt_a;
  int              m_cnt_b;
  logic [WIDTH-1:0] exp_q[$]; // accepted words awaiting consumption

  rr_arb_2_1 #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .a_valid   (a_valid),
    .a_data    (a_data),
    .a_ready   (a_ready),
    .b_valid   (b_valid),
    .b_data    (b_data),
    .b_ready   (b_ready),
    .sel       (sel),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .cnt_a     (cnt_a),
    .cnt_b     (cnt_b)
  );

  // Clock: rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    m_data  = '0;
    m_last  = 1;
    m_cnt_a = 0;
    m_cnt_b = 0;
    exp_q.delete();
  endtask

  // Asserts reset away from any clock edge and checks its immediate effect.
  task automatic do_reset();
    #2;
    rst     = 1'b1;
    a_valid = 1'b1;
    b_valid = 1'b1;
    out_ready = 1'b1;
    #1;
    model_reset();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data",  32'(out_data),  32'd0);
    check("rst_cnt_a",     32'(cnt_a),     32'd0);
    check("rst_cnt_b",     32'(cnt_b),     32'd0);
    check("rst_a_ready",   32'(a_ready),   32'd0);
    check("rst_b_ready",   32'(b_ready),   32'd0);
    @(posedge clk);
    #1;
    check("rst_hold_valid", 32'(out_valid), 32'd0);
    check("rst_hold_cnt_a", 32'(cnt_a),     32'd0);
    @(negedge clk);
    rst     = 1'b0;
    a_valid = 1'b0;
    b_valid = 1'b0;
  endtask

  // One clock cycle: drive after the falling edge, check the combinational
  // grant, take the rising edge, then check registered outputs.
  task automatic cycle(input logic av, input logic [WIDTH-1:0] ad,
                       input logic bv, input logic [WIDTH-1:0] bd,
                       input logic ory);
    int  e_sel;
    bit  e_load;
    logic [WIDTH-1:0] popped;
    @(negedge clk);
    a_valid   = av;
    a_data    = ad;
    b_valid   = bv;
    b_data    = bd;
    out_ready = ory;
    #1;
    // Round-robin rule: lone requester wins; on a tie the loser of the
    // previous grant wins; idle selects A.
    if (av && bv)  e_sel = 1 - m_last;
    else if (bv)   e_sel = 1;
    else           e_sel = 0;
    e_load = (!m_valid || ory) && (av || bv);
    check("sel",     32'(sel),     32'(e_sel));
    check("a_ready", 32'(a_ready), 32'(e_load && e_sel == 0));
    check("b_ready", 32'(b_ready), 32'(e_load && e_sel == 1));
    if (m_valid && ory) begin
      if (exp_q.size() == 0) begin
        check("sb_underflow", 32'd1, 32'd0);
      end else begin
        popped = exp_q.pop_front();
        check("sb_consume", 32'(out_data), 32'(popped));
      end
    end
    @(posedge clk);
    #1;
    if (e_load) begin
      m_valid = 1'b1;
      m_data  = (e_sel == 1) ? bd : ad;
      m_last  = e_sel;
      exp_q.push_back(m_data);
      if (e_sel == 0) m_cnt_a = (m_cnt_a + 1) % 65536;
      else            m_cnt_b = (m_cnt_b + 1) % 65536;
    end else if (m_valid && ory) begin
      m_valid = 1'b0;
    end
    check("out_valid", 32'(out_valid), 32'(m_valid));
    check("out_data",  32'(out_data),  32'(m_data));
    check("cnt_a",     32'(cnt_a),     32'(m_cnt_a));
    check("cnt_b",     32'(cnt_b),     32'(m_cnt_b));
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    rst       = 1'b0;
    a_valid   = 1'b0;
    b_valid   = 1'b0;
    a_data    = '0;
    b_data    = '0;
    out_ready = 1'b0;
    model_reset();

    // Sustained tie alternates A,B,A,B starting with A.
    do_reset();
    cycle(1, 8'h11, 1, 8'h22, 1); check("alt0", 32'(out_data), 32'h11);
    cycle(1, 8'h11, 1, 8'h22, 1); check("alt1", 32'(out_data), 32'h22);
    cycle(1, 8'h11, 1, 8'h22, 1); check("alt2", 32'(out_data), 32'h11);
    cycle(1, 8'h11, 1, 8'h22, 1); check("alt3", 32'(out_data), 32'h22);
    check("alt_cnt_a", 32'(cnt_a), 32'd2);
    check("alt_cnt_b", 32'(cnt_b), 32'd2);

    // Lone B request, then the next tie goes to A.
    do_reset();
    cycle(0, 8'h00, 1, 8'h5A, 1); check("b_only", 32'(out_data), 32'h5A);
    cycle(1, 8'h11, 1, 8'h22, 1); check("tie_after_b", 32'(out_data), 32'h11);

    // Backpressure hold, then B wins the tie.
    do_reset();
    cycle(1, 8'h33, 0, 8'h00, 1);
    for (int i = 0; i < 3; i++) begin
      cycle(1, 8'h44, 1, 8'h55, 0);
      check("hold_data", 32'(out_data), 32'h33);
    end
    check("hold_cnt_a", 32'(cnt_a), 32'd1);
    check("hold_cnt_b", 32'(cnt_b), 32'd0);
    cycle(1, 8'h44, 1, 8'h55, 1); check("after_hold", 32'(out_data), 32'h55);

    // Drain to EMPTY with data retained.
    cycle(0, 8'h00, 0, 8'h00, 1);
    check("drain_valid", 32'(out_valid), 32'd0);
    check("drain_data",  32'(out_data),  32'h55);

    // Counter wrap on A.
    do_reset();
    for (int i = 0; i < 65535; i++) cycle(1, 8'(i), 0, 8'h00, 1);
    check("cnt_a_full", 32'(cnt_a), 32'hFFFF);
    cycle(1, 8'hA5, 0, 8'h00, 1);
    check("cnt_a_wrap", 32'(cnt_a), 32'd0);
    check("cnt_b_keep", 32'(cnt_b), 32'd0);

    // Reset mid-stream with out_valid high, then first tie to A.
    cycle(1, 8'h66, 1, 8'h77, 1);
    cycle(1, 8'h66, 1, 8'h77, 1);
    do_reset();
    cycle(1, 8'h11, 1, 8'h22, 1); check("tie_after_rst", 32'(out_data), 32'h11);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) do_reset();
      cycle(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
            8'($urandom), 1'($urandom_range(0, 3) != 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rr_arb_2_1.md
RR_ARB_2_1 -- requirements
Module: rr_arb_2_1

Interface
REQ-001 Parameter WIDTH, default 8, data width of each source and of the output.
REQ-002 Parameter CNT_W, default 16, width of each grant counter.
REQ-003 Port clk, input, 1: sole clock; all state updates on rising edge.
REQ-004 Port rst, input, 1: asynchronous, active-high reset.
REQ-005 Port a_valid, input, 1: source A offers a_data.
REQ-006 Port a_data, input, WIDTH: source A payload.
REQ-007 Port a_ready, output, 1: source A word accepted this cycle when a_valid also high.
REQ-008 Port b_valid, input, 1: source B offers b_data.
REQ-009 Port b_data, input, WIDTH: source B payload.
REQ-010 Port b_ready, output, 1: source B word accepted this cycle when b_valid also high.
REQ-011 Port sel, output, 1: combinational grant, 0 = A, 1 = B; drives the select of the downstream 2:1 mux.
REQ-012 Port out_valid, output, 1: out_data holds a valid word.
REQ-013 Port out_data, output, WIDTH: registered granted payload.
REQ-014 Port out_ready, input, 1: consumer takes out_data this cycle when out_valid high.
REQ-015 Port cnt_a, output, CNT_W: count of words accepted from A.
REQ-016 Port cnt_b, output, CNT_W: count of words accepted from B.

Function
REQ-017 Single output register with two states: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-018 load = (EMPTY or out_ready) and (a_valid or b_valid).
REQ-019 Grant: only A valid -> A; only B valid -> B; both valid -> source not in last_grant; neither -> sel=0.
REQ-020 last_grant is internal, 1 bit; it updates to the granted source only on load.
REQ-021 a_ready = load and sel==0; b_ready = load and sel==1; never both high.
REQ-022 On load: out_data <= granted data, out_valid <= 1, next cycle (latency 1).
REQ-023 FULL and out_ready and no source valid -> EMPTY, out_data holds its last value.
REQ-024 FULL and not out_ready -> out_data and out_valid are held stable, a_ready=b_ready=0.
REQ-025 FULL, out_ready and a source valid -> same-cycle pass-through of the handoff: old word consumed, new word loaded, out_valid stays 1 (full throughput, one word per cycle).
REQ-026 sel, a_ready, b_ready are combinational from a_valid, b_valid, state, out_ready, last_grant; no combinational path from data to control.
REQ-027 cnt_a increments by 1 on each A accept, cnt_b on each B accept; wrap from all-ones to 0 with no saturation.
REQ-028 Valid deassertion by a source without acceptance is legal; the arbiter makes no assumption of source stickiness.
REQ-029 Sustained both-valid with out_ready=1 gives strict alternation A,B,A,B...

Reset
REQ-030 rst high asynchronously forces out_valid=0, out_data=0, cnt_a=0, cnt_b=0, last_grant=B (so A wins the first tie), state EMPTY.
REQ-031 While rst high, a_ready=b_ready=0; a word in flight when rst asserts is dropped and not counted.
REQ-032 First load is possible on the first rising edge after rst deasserts.

Verification
REQ-033 After reset, a_valid=b_valid=1, a_data=8'h11, b_data=8'h22, out_ready=1 for 4 cycles -> out_data 11,22,11,22 on consecutive cycles; cnt_a=2, cnt_b=2.
REQ-034 Only b_valid=1, b_data=8'h5A, out_ready=1 -> sel=1, b_ready=1, out_data=8'h5A next cycle; last_grant=B, so the next tie goes to A.
REQ-035 Load 8'h33 from A, then out_ready=0 for 3 cycles with both sources valid -> out_data stays 8'h33, a_ready=b_ready=0, counters frozen; out_ready=1 -> B granted next.
REQ-036 FULL, out_ready=1, no source valid -> out_valid=0 next cycle, out_data unchanged.
REQ-037 Preload cnt_a to all-ones via 65535 A accepts, then 1 more -> cnt_a=0, cnt_b unchanged.
REQ-038 Assert rst mid-stream with out_valid=1 -> out_valid, out_data, counters =0 immediately, before the next clock edge; the first tie after release goes to A.
